// File: rtl/snake_pkg.sv
// Shared types for the snake game: directions, grid coordinates and
// default grid dimensions used by snake_body and snake_pos_ring.
package snake_pkg;

    localparam int DEF_GRID_W = 16;
    localparam int DEF_GRID_H = 16;
    // Coordinate fields are wide enough for grids up to 256x256.
    localparam int COORD_W    = 8;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    function automatic dir_t opposite(input dir_t d);
        dir_t o;
        case (d)
            DIR_LEFT:  o = DIR_RIGHT;
            DIR_RIGHT: o = DIR_LEFT;
            DIR_UP:    o = DIR_DOWN;
            DIR_DOWN:  o = DIR_UP;
            default:   o = DIR_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/snake_pos_ring.sv
// Circular buffer of body coordinates, head at head_ptr, tail at tail_ptr.
// Ports: clk, reset (sync, loads preload/pointers), push + push_data
// (new head), pop (drop tail), head/tail combinational read ports.
module snake_pos_ring
    import snake_pkg::*;
#(
    parameter  int MAX_LEN = 32,
    localparam int PW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  coord_t        preload [MAX_LEN],
    input  logic [PW-1:0] preload_head,
    input  logic [PW-1:0] preload_tail,
    input  logic          push,
    input  coord_t        push_data,
    input  logic          pop,
    output coord_t        head,
    output coord_t        tail
);

    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_LEN - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    coord_t        mem_q [MAX_LEN];
    coord_t        mem_d [MAX_LEN];
    logic [PW-1:0] hp_q, hp_d;
    logic [PW-1:0] tp_q, tp_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    always_comb begin
        mem_d = mem_q;
        hp_d  = hp_q;
        tp_d  = tp_q;
        if (push) begin
            hp_d        = ptr_inc(hp_q);
            mem_d[hp_d] = push_data;
        end
        if (pop) begin
            tp_d = ptr_inc(tp_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= preload;
            hp_q  <= preload_head;
            tp_q  <= preload_tail;
        end else begin
            mem_q <= mem_d;
            hp_q  <= hp_d;
            tp_q  <= tp_d;
        end
    end

    assign head = mem_q[hp_q];
    assign tail = mem_q[tp_q];

endmodule

// File: rtl/snake_body.sv
// Snake position tracker: FSM, next-head arithmetic, wall/self collision,
// growth and the occupancy bitmap read row by row by the display.
// Ports: clk, reset, left/right/up/down levels, step tick, food_x/food_y,
// row_sel -> row_bits, head_x/head_y, length, ate pulse, game_over level.
module snake_body
    import snake_pkg::*;
#(
    parameter  int GRID_W    = DEF_GRID_W,
    parameter  int GRID_H    = DEF_GRID_H,
    parameter  int MAX_LEN   = 32,
    parameter  int START_LEN = 3,
    localparam int XW        = $clog2(GRID_W),
    localparam int YW        = $clog2(GRID_H),
    localparam int LW        = $clog2(MAX_LEN + 1),
    localparam int PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              left,
    input  logic              right,
    input  logic              up,
    input  logic              down,
    input  logic              step,
    input  logic [XW-1:0]     food_x,
    input  logic [YW-1:0]     food_y,
    input  logic [YW-1:0]     row_sel,
    output logic [GRID_W-1:0] row_bits,
    output logic [XW-1:0]     head_x,
    output logic [YW-1:0]     head_y,
    output logic [LW-1:0]     length,
    output logic              ate,
    output logic              game_over
);

    typedef enum logic [1:0] {
        ST_START,
        ST_RUN,
        ST_DEAD
    } state_t;

    localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);
    localparam logic [LW-1:0]      L_ONE  = LW'(1);
    localparam logic [LW-1:0]      L_MAX  = LW'(MAX_LEN);

    state_t                         state_q, state_d;
    dir_t                           last_dir_q, last_dir_d;
    logic [LW-1:0]                  len_q, len_d;
    logic                           ate_q, ate_d;
    logic [GRID_H-1:0][GRID_W-1:0]  bmp_q, bmp_d;
    logic [GRID_H-1:0][GRID_W-1:0]  bmp_init;

    coord_t preload [MAX_LEN];
    coord_t head_c;
    coord_t tail_c;
    coord_t nh;
    dir_t   req;
    dir_t   mv_dir;
    logic   wall;
    logic   grow;
    logic   self_hit;
    logic   do_move;
    logic   push;
    logic   pop;

    // Starting body: row GRID_H/2, tail at column 1, head at START_LEN.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < START_LEN) begin
                preload[i].x = COORD_W'(i + 1);
                preload[i].y = COORD_W'(GRID_H / 2);
            end else begin
                preload[i] = '0;
            end
        end
        bmp_init = '0;
        for (int i = 1; i <= START_LEN; i++) begin
            bmp_init[GRID_H/2][i] = 1'b1;
        end
    end

    snake_pos_ring #(
        .MAX_LEN (MAX_LEN)
    ) u_ring (
        .clk          (clk),
        .reset        (reset),
        .preload      (preload),
        .preload_head (PW'(START_LEN - 1)),
        .preload_tail ('0),
        .push         (push),
        .push_data    (nh),
        .pop          (pop),
        .head         (head_c),
        .tail         (tail_c)
    );

    always_comb begin
        req = DIR_NONE;
        if (left) begin
            req = DIR_LEFT;
        end else if (right) begin
            req = DIR_RIGHT;
        end else if (up) begin
            req = DIR_UP;
        end else if (down) begin
            req = DIR_DOWN;
        end

        mv_dir = (req == DIR_NONE) ? last_dir_q : req;
        // A snake cannot reverse into its own neck.
        if (mv_dir == opposite(last_dir_q)) begin
            mv_dir = last_dir_q;
        end

        nh   = head_c;
        wall = 1'b0;
        case (mv_dir)
            DIR_LEFT: begin
                wall = (head_c.x == '0);
                nh.x = head_c.x - C_ONE;
            end
            DIR_RIGHT: begin
                wall = (head_c.x == X_LAST);
                nh.x = head_c.x + C_ONE;
            end
            DIR_UP: begin
                wall = (head_c.y == '0);
                nh.y = head_c.y - C_ONE;
            end
            DIR_DOWN: begin
                wall = (head_c.y == Y_LAST);
                nh.y = head_c.y + C_ONE;
            end
            default: ;
        endcase

        grow = (nh.x == COORD_W'(food_x)) && (nh.y == COORD_W'(food_y));

        // Moving onto the tail is safe only when the tail leaves this step.
        self_hit = !wall
                && bmp_q[nh.y[YW-1:0]][nh.x[XW-1:0]]
                && !((nh == tail_c) && !grow);

        do_move = step
               && ((state_q == ST_RUN)
                || ((state_q == ST_START) && (req != DIR_NONE)));

        state_d    = state_q;
        last_dir_d = last_dir_q;
        len_d      = len_q;
        ate_d      = 1'b0;
        bmp_d      = bmp_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (do_move) begin
            last_dir_d = mv_dir;
            if (wall || self_hit) begin
                state_d = ST_DEAD;
            end else begin
                state_d = ST_RUN;
                push    = 1'b1;
                ate_d   = grow;
                if (grow && (len_q < L_MAX)) begin
                    len_d = len_q + L_ONE;
                end else begin
                    pop = 1'b1;
                    bmp_d[tail_c.y[YW-1:0]][tail_c.x[XW-1:0]] = 1'b0;
                end
                // Head set after tail clear so it wins on a shared cell.
                bmp_d[nh.y[YW-1:0]][nh.x[XW-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_START;
            last_dir_q <= DIR_RIGHT;
            len_q      <= LW'(START_LEN);
            ate_q      <= 1'b0;
            bmp_q      <= bmp_init;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            len_q      <= len_d;
            ate_q      <= ate_d;
            bmp_q      <= bmp_d;
        end
    end

    assign row_bits  = bmp_q[row_sel];
    assign head_x    = head_c.x[XW-1:0];
    assign head_y    = head_c.y[YW-1:0];
    assign length    = len_q;
    assign ate       = ate_q;
    assign game_over = (state_q == ST_DEAD);

endmodule

// File: tb/tb_snake_body.sv
// Self-checking bench for snake_body: scoreboard of expected head/length/
// ate/game_over per cycle plus direct bitmap row checks.
module tb_snake_body;

    localparam logic [3:0] N = 4'b0000;
    localparam logic [3:0] L = 4'b1000;
    localparam logic [3:0] R = 4'b0100;
    localparam logic [3:0] U = 4'b0010;
    localparam logic [3:0] D = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        left, right, up, down, step;
    logic [3:0]  food_x, food_y, row_sel;
    logic [15:0] row_bits;
    logic [3:0]  head_x, head_y;
    logic [5:0]  length;
    logic        ate, game_over;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int hx;
        int hy;
        int len;
        int at;
        int go;
    } exp_t;

    exp_t sb[$];

    snake_body dut (
        .clk       (clk),
        .reset     (reset),
        .left      (left),
        .right     (right),
        .up        (up),
        .down      (down),
        .step      (step),
        .food_x    (food_x),
        .food_y    (food_y),
        .row_sel   (row_sel),
        .row_bits  (row_bits),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .ate       (ate),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push its expectation, then pop and compare after the edge.
    task automatic cyc(input string tag, input logic [3:0] dirs,
                       input logic stp, input logic rst,
                       input int hx, input int hy, input int len,
                       input int at, input int go);
        exp_t e;
        e = '{hx, hy, len, at, go};
        sb.push_back(e);
        @(negedge clk);
        {left, right, up, down} = dirs;
        step  = stp;
        reset = rst;
        @(posedge clk);
        #1;
        {left, right, up, down} = N;
        step  = 1'b0;
        reset = 1'b0;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, " head_x"}, 32'(head_x), e.hx);
            check({tag, " head_y"}, 32'(head_y), e.hy);
            check({tag, " length"}, 32'(length), e.len);
            check({tag, " ate"}, 32'(ate), e.at);
            check({tag, " game_over"}, 32'(game_over), e.go);
        end
    endtask

    task automatic check_row(input string tag, input int row,
                             input logic [15:0] exp);
        row_sel = row[3:0];
        #1;
        check(tag, 32'(row_bits), 32'(exp));
    endtask

    task automatic do_reset(input string tag, input logic stp);
        cyc(tag, R, stp, 1'b1, 3, 8, 3, 0, 0);
        check_row({tag, " row8"}, 8, 16'h000E);
        check_row({tag, " row7"}, 7, 16'h0000);
        check_row({tag, " row9"}, 9, 16'h0000);
    endtask

    task automatic grow_then_chase(input logic eat_last);
        food_x = 4'd4;
        food_y = 4'd8;
        cyc("grow", R, 1'b1, 1'b0, 4, 8, 4, 1, 0);
        check_row("grow row8", 8, 16'h001E);
        food_x = 4'd0;
        food_y = 4'd0;
        cyc("grow idle", N, 1'b0, 1'b0, 4, 8, 4, 0, 0);
        cyc("chase up", U, 1'b1, 1'b0, 4, 7, 4, 0, 0);
        cyc("chase left", L, 1'b1, 1'b0, 3, 7, 4, 0, 0);
        if (eat_last) begin
            food_x = 4'd3;
            food_y = 4'd8;
            cyc("chase eat", D, 1'b1, 1'b0, 3, 7, 4, 0, 1);
            food_x = 4'd0;
            food_y = 4'd0;
            check_row("chase eat row8", 8, 16'h0018);
            check_row("chase eat row7", 7, 16'h0018);
        end else begin
            cyc("chase down", D, 1'b1, 1'b0, 3, 8, 4, 0, 0);
            check_row("chase row8", 8, 16'h0018);
            check_row("chase row7", 7, 16'h0018);
        end
    endtask

    initial begin
        int hx;
        int hy;
        logic [3:0] seg_dir [5];
        int         seg_len [5];

        reset = 1'b1;
        {left, right, up, down} = N;
        step    = 1'b0;
        food_x  = 4'd0;
        food_y  = 4'd0;
        row_sel = 4'd0;
        repeat (2) @(posedge clk);

        do_reset("reset", 1'b0);
        cyc("nodir step", N, 1'b1, 1'b0, 3, 8, 3, 0, 0);
        check_row("nodir row8", 8, 16'h000E);

        for (int k = 1; k <= 12; k++) begin
            cyc($sformatf("wall %0d", k), R, 1'b1, 1'b0, 3 + k, 8, 3, 0, 0);
        end
        check_row("wall row8", 8, 16'hE000);
        cyc("wall hit", R, 1'b1, 1'b0, 15, 8, 3, 0, 1);
        cyc("dead step", U, 1'b1, 1'b0, 15, 8, 3, 0, 1);
        check_row("dead row8", 8, 16'hE000);

        do_reset("reset dead", 1'b0);
        grow_then_chase(1'b0);

        do_reset("reset chase", 1'b0);
        grow_then_chase(1'b1);
        cyc("dead frozen", R, 1'b1, 1'b0, 3, 7, 4, 0, 1);

        do_reset("reset from dead", 1'b0);
        cyc("reverse start", L, 1'b1, 1'b0, 4, 8, 3, 0, 0);
        cyc("reverse run", L, 1'b1, 1'b0, 5, 8, 3, 0, 0);

        do_reset("reset on step", 1'b1);

        // Serpentine path long enough to wrap the ring pointers.
        seg_dir = '{R, D, L, D, R};
        seg_len = '{12, 1, 15, 1, 5};
        hx = 3;
        hy = 8;
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < seg_len[s]; k++) begin
                case (seg_dir[s])
                    R: hx = hx + 1;
                    L: hx = hx - 1;
                    D: hy = hy + 1;
                    default: hy = hy - 1;
                endcase
                cyc($sformatf("snake s%0d k%0d", s, k), seg_dir[s], 1'b1,
                    1'b0, hx, hy, 3, 0, 0);
            end
        end
        check_row("snake row10", 10, 16'h0038);
        check_row("snake row9", 9, 16'h0000);
        check_row("snake row8", 8, 16'h0000);

        check("sb drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_body.md
# snake_body

Tracks the snake's position on the LED grid. Consumes the one-hot direction levels from the user-input stage (left/right/up/down) and a move-tick pulse, advances the head one cell per tick, grows when the head lands on food, and detects wall and self collisions. Holds the body as a coordinate ring buffer plus an occupancy bitmap, which the display driver reads row by row.

## Interface
- GRID_W, 16, grid columns (x: 0 = left)
- GRID_H, 16, grid rows (y: 0 = top)
- MAX_LEN, 32, maximum snake length (ring depth)
- START_LEN, 3, length after reset; 2 ≤ START_LEN ≤ min(MAX_LEN, GRID_W-1)
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- left, right, up, down  in  1 each  direction levels from the user-input stage; priority left>right>up>down if more than one is high
- step  in  1  single-cycle move tick from the game-speed divider
- food_x  in  $clog2(GRID_W)  food column
- food_y  in  $clog2(GRID_H)  food row
- row_sel  in  $clog2(GRID_H)  display row to read
- row_bits  out  GRID_W  occupancy of row row_sel; bit i = column i
- head_x, head_y  out  coord widths  current head cell
- length  out  $clog2(MAX_LEN+1)  current length
- ate  out  1  one-cycle pulse: the last step ate food
- game_over  out  1  level; high in DEAD

## Operation
- States: START (waiting for the first direction), RUN, DEAD.
- Reset (and reset in any state, mid-move included) loads START. The body is row GRID_H/2, columns START_LEN down to 1. Head = (START_LEN, GRID_H/2). length = START_LEN. last_dir = RIGHT. ate = 0, game_over = 0. Bitmap holds exactly those cells.
- START: a step with no direction is ignored. A step with a direction executes a move and enters RUN.
- RUN, on step: req = the highest-priority asserted direction, or last_dir if none. A req opposite to last_dir is replaced by last_dir. last_dir <= req.
- New head: LEFT x-1, RIGHT x+1, UP y-1, DOWN y+1. Leaving the grid (x<0, x≥GRID_W, y<0, y≥GRID_H) → DEAD.
- grow = (new head == food). tail_free = !grow (the tail cell is vacated this move).
- Self collision: bitmap[new head] is set, unless new head == tail cell and tail_free → DEAD.
- Legal move: push the new head. If grow and length < MAX_LEN: length+1, tail kept. Otherwise pop the tail and clear its bitmap bit. Eating at MAX_LEN still pulses ate, and length saturates. Tail clear and head set happen in the same cycle, with head set winning on the same cell.
- DEAD: head, length and bitmap are frozen. step and direction inputs are ignored until reset.
- Food placed on the body is the upstream placer's responsibility. It is not checked here.

## Timing
- A step sampled on edge N updates head, length, bitmap, state, ate and game_over, all visible after edge N. Latency is 1 cycle. A new step is accepted every cycle.
- ate is high for exactly the cycle after the eating edge.
- row_bits is combinational from the registered bitmap and row_sel. No read latency.
- Ring head and tail pointers wrap from MAX_LEN-1 to 0.
- All state is registered. There are no combinational paths from step to outputs.

## Structure
- snake_pkg:
  - dir_t enum {DIR_NONE, DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} and an opposite() function
  - coord_t struct {x, y}
  - default GRID_W/GRID_H constants
- Sub-module snake_pos_ring: a MAX_LEN-deep circular buffer of coord_t. It has push (new head) and pop (tail) in the same cycle, plus combinational head/tail read ports. The reset preload comes from the parent.
- snake_body holds the FSM, next-head arithmetic, collision logic and the GRID_W×GRID_H bitmap.

## Test plan
Defaults apply, and food is at (0,0) unless stated.
- Reset: head (3,8), length 3, row 8 = 0x000E, game_over 0. A step with no direction leaves all of these unchanged.
- Wall: right + 12 steps → head (15,8), game_over 0. The 13th step → game_over 1, head stays (15,8). Further steps change nothing.
- Grow: food (4,8), right + step → ate 1 for one cycle, length 4, row 8 = 0x001E.
- Reverse ignored: in RUN going right at (3,8), left + step → head (4,8), game_over 0.
- Tail chase: after the grow test, step up, left, down → head (3,8), game_over 0, length 4, cells {(3,8),(3,7),(4,7),(4,8)}. Repeat with food at (3,8) on the final step → game_over 1.
- Reset mid-game: assert reset while DEAD, and separately on a step cycle → next cycle matches the reset scenario exactly.
